// File: rtl/trigger_link_framer.sv
// GEM trigger link framer: packs per-BX cluster groups into 16-bit + K-flag
// frames on NLINKS GTX lanes, with BC0 / marker / overflow / idle control
// characters and data, all-ones, BX-counter and PRBS-15 test modes.
// Ports: clock, reset_n (sync, active-low), clusters_i, overflow_i,
//        resync_i, mode_i -> link_data_o, link_isk_o, frame_o, bc0_o,
//        marker_o, ovf_dropped_o.
module trigger_link_framer #(
  parameter int NCLUSTERS         = 8,
  parameter int CLUSTER_BITS      = 14,
  parameter int CLUSTERS_PER_LINK = 4,
  parameter int LINK_COPIES       = 2,
  parameter int FRAMES_PER_BX     = 4,
  parameter int BC0_PERIOD        = 3564,
  parameter int MARKER_PERIOD     = 128,
  localparam int NLINKS =
    NCLUSTERS / CLUSTERS_PER_LINK * LINK_COPIES,
  localparam int FW =
    (FRAMES_PER_BX > 1) ? $clog2(FRAMES_PER_BX) : 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NCLUSTERS*CLUSTER_BITS-1:0] clusters_i,
  input  logic                              overflow_i,
  input  logic                              resync_i,
  input  logic [1:0]                        mode_i,
  output logic [NLINKS*16-1:0]              link_data_o,
  output logic [NLINKS*2-1:0]               link_isk_o,
  output logic [FW-1:0]                     frame_o,
  output logic                              bc0_o,
  output logic                              marker_o,
  output logic                              ovf_dropped_o
);

  localparam int NGROUPS = NCLUSTERS / CLUSTERS_PER_LINK;
  localparam int GW  = CLUSTERS_PER_LINK * CLUSTER_BITS;
  localparam int PW  = FRAMES_PER_BX * 16 - 8;
  localparam int BW  = FRAMES_PER_BX * 16;
  localparam int BXW = $clog2(BC0_PERIOD);
  localparam int MKW = $clog2(MARKER_PERIOD);

  localparam logic [FW-1:0]  FLAST  = FW'(FRAMES_PER_BX - 1);
  localparam logic [BXW-1:0] BXLAST = BXW'(BC0_PERIOD - 1);
  localparam logic [MKW-1:0] MKLAST = MKW'(MARKER_PERIOD - 1);

  logic [FW-1:0]         r_frame_cnt;
  logic [BXW-1:0]        r_bx_cnt;
  logic [MKW-1:0]        r_mk_cnt;
  logic [14:0]           r_lfsr;
  logic                  r_resync_pend;
  logic [NGROUPS*BW-1:0] r_buf;

  logic                    w_boundary;
  logic [BXW-1:0]          w_bx_next;
  logic [MKW-1:0]          w_mk_next;
  logic                    w_bc0;
  logic                    w_marker;
  logic                    w_ovf;
  logic [7:0]              w_ctrl;
  logic [CLUSTER_BITS-1:0] w_bx_slot;
  logic [CLUSTER_BITS-1:0] w_lfsr_slot;
  logic [14:0]             w_lfsr_next;
  logic [FW-1:0]           w_fnext;
  logic [NGROUPS*BW-1:0]   w_buf;
  logic [NLINKS*16-1:0]    w_word0;
  logic [NLINKS*16-1:0]    w_wordk;

  assign w_boundary = (r_frame_cnt == FLAST);
  assign w_fnext    = r_frame_cnt + FW'(1);

  // A resync seen on the boundary cycle itself counts immediately.
  always_comb begin
    if (r_resync_pend || resync_i)
      w_bx_next = '0;
    else if (r_bx_cnt == BXLAST)
      w_bx_next = '0;
    else
      w_bx_next = r_bx_cnt + BXW'(1);
  end

  // BC0 restarts the marker spacing.
  always_comb begin
    if (w_bx_next == '0)
      w_mk_next = '0;
    else if (r_mk_cnt == MKLAST)
      w_mk_next = '0;
    else
      w_mk_next = r_mk_cnt + MKW'(1);
  end

  assign w_bc0    = (w_bx_next == '0);
  assign w_marker = !w_bc0 && (w_mk_next == '0);
  assign w_ovf    = overflow_i && (mode_i == 2'd0);

  always_comb begin
    w_ctrl = 8'hBC;
    if (w_bc0)
      w_ctrl = 8'h1C;
    else if (w_marker)
      w_ctrl = 8'hFC;
    else if (w_ovf)
      w_ctrl = 8'hDC;
  end

  assign w_bx_slot   = CLUSTER_BITS'(w_bx_next);
  assign w_lfsr_slot = CLUSTER_BITS'(r_lfsr);
  assign w_lfsr_next = {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};

  // Whole-BX frame per group: {payload, ctrl}, word k at bits [16k+:16].
  always_comb begin
    logic [GW-1:0] w_grp;
    w_buf = '0;
    for (int g = 0; g < NGROUPS; g++) begin
      w_grp = '0;
      for (int s = 0; s < CLUSTERS_PER_LINK; s++) begin
        case (mode_i)
          2'd0: w_grp[s*CLUSTER_BITS +: CLUSTER_BITS] =
                  clusters_i[(g*CLUSTERS_PER_LINK+s)*CLUSTER_BITS
                             +: CLUSTER_BITS];
          2'd1: w_grp[s*CLUSTER_BITS +: CLUSTER_BITS] = '1;
          2'd2: w_grp[s*CLUSTER_BITS +: CLUSTER_BITS] = w_bx_slot;
          default:
                w_grp[s*CLUSTER_BITS +: CLUSTER_BITS] = w_lfsr_slot;
        endcase
      end
      w_buf[g*BW +: BW] = {PW'(w_grp), w_ctrl};
    end
  end

  always_comb begin
    w_word0 = '0;
    w_wordk = '0;
    for (int l = 0; l < NLINKS; l++) begin
      w_word0[l*16 +: 16] = w_buf[(l/LINK_COPIES)*BW +: 16];
      w_wordk[l*16 +: 16] =
        r_buf[(l/LINK_COPIES)*BW + 16*int'(w_fnext) +: 16];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_frame_cnt   <= FLAST;
      r_bx_cnt      <= BXLAST;
      r_mk_cnt      <= MKLAST;
      r_lfsr        <= 15'h7FFF;
      r_resync_pend <= 1'b0;
      r_buf         <= '0;
      link_data_o   <= {NLINKS{16'h00BC}};
      link_isk_o    <= {NLINKS{2'b01}};
      frame_o       <= '0;
      bc0_o         <= 1'b0;
      marker_o      <= 1'b0;
      ovf_dropped_o <= 1'b0;
    end else if (w_boundary) begin
      r_frame_cnt   <= '0;
      r_bx_cnt      <= w_bx_next;
      r_mk_cnt      <= w_mk_next;
      r_lfsr        <= w_lfsr_next;
      r_resync_pend <= 1'b0;
      r_buf         <= w_buf;
      link_data_o   <= w_word0;
      link_isk_o    <= {NLINKS{2'b01}};
      frame_o       <= '0;
      bc0_o         <= w_bc0;
      marker_o      <= w_marker;
      ovf_dropped_o <= w_ovf && (w_bc0 || w_marker);
    end else begin
      r_frame_cnt   <= w_fnext;
      if (resync_i)
        r_resync_pend <= 1'b1;
      link_data_o   <= w_wordk;
      link_isk_o    <= '0;
      frame_o       <= w_fnext;
      bc0_o         <= 1'b0;
      marker_o      <= 1'b0;
      ovf_dropped_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trigger_link_framer.sv
// Bench for trigger_link_framer: randomized BX traffic checked every cycle
// against an orbit-level reference model, plus directed boundary steps.
module tb_trigger_link_framer;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [111:0] clusters_i;
  logic         overflow_i;
  logic         resync_i;
  logic [1:0]   mode_i;
  logic [63:0]  link_data_o;
  logic [7:0]   link_isk_o;
  logic [1:0]   frame_o;
  logic         bc0_o;
  logic         marker_o;
  logic         ovf_dropped_o;

  always #5 clock = ~clock;

  trigger_link_framer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clusters_i    (clusters_i),
    .overflow_i    (overflow_i),
    .resync_i      (resync_i),
    .mode_i        (mode_i),
    .link_data_o   (link_data_o),
    .link_isk_o    (link_isk_o),
    .frame_o       (frame_o),
    .bc0_o         (bc0_o),
    .marker_o      (marker_o),
    .ovf_dropped_o (ovf_dropped_o)
  );

  int vectors = 0;
  int miscompares = 0;

  int        m_bx;
  int        m_since;
  bit [14:0] m_lfsr;
  bit        m_force_bc0;

  bit [15:0] obs_l0 [4];
  bit [15:0] obs_l2 [4];
  bit        obs_bc0, obs_mk, obs_drop;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t",
             tag, obs, exp, $time);
    end
  endtask

  function automatic bit [111:0] rnd_cl();
    return 112'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic bit [14:0] lfsr_next(input bit [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  function automatic bit [15:0] frame_word(input bit [55:0] p,
                                           input bit [7:0] c,
                                           input int k);
    bit [63:0] f;
    f = {p, c};
    return 16'(f >> (16 * k));
  endfunction

  task automatic model_reset();
    m_force_bc0 = 1'b1;
    m_lfsr      = 15'h7FFF;
    m_bx        = 0;
    m_since     = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_data"}, link_data_o, 64'h00BC00BC00BC00BC);
    chk({tag, "_isk"}, link_isk_o, 8'h55);
    chk({tag, "_frame"}, frame_o, 0);
    chk({tag, "_bc0"}, bc0_o, 0);
    chk({tag, "_mk"}, marker_o, 0);
    chk({tag, "_drop"}, ovf_dropped_o, 0);
  endtask

  // Entered with the DUT on the last word of a BX (or leaving reset).
  task automatic run_bx(input bit [111:0] cl, input bit ovf,
                        input bit [1:0] md, input bit rs_edge,
                        input bit rs_mid);
    bit        bc0, mk, oe, drop;
    bit [7:0]  ctrl;
    bit [55:0] p [2];
    bit [13:0] slot;
    bit [63:0] exp;
    if (m_force_bc0 || rs_edge) m_bx = 0;
    else m_bx = (m_bx + 1) % 3564;
    m_force_bc0 = 1'b0;
    m_since = (m_bx == 0) ? 0 : m_since + 1;
    bc0  = (m_bx == 0);
    mk   = !bc0 && (m_since % 128 == 0);
    oe   = ovf && (md == 2'd0);
    drop = oe && (bc0 || mk);
    ctrl = bc0 ? 8'h1C : mk ? 8'hFC : oe ? 8'hDC : 8'hBC;
    for (int g = 0; g < 2; g++) begin
      p[g] = '0;
      for (int s = 0; s < 4; s++) begin
        case (md)
          2'd0: slot = cl[(g*4+s)*14 +: 14];
          2'd1: slot = 14'h3FFF;
          2'd2: slot = 14'(m_bx);
          default: slot = m_lfsr[13:0];
        endcase
        p[g] = p[g] | (56'(slot) << (14 * s));
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
    clusters_i = cl;
    overflow_i = ovf;
    mode_i     = md;
    resync_i   = rs_edge;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int l = 0; l < 4; l++)
        exp[l*16 +: 16] = frame_word(p[l/2], ctrl, k);
      chk("data", link_data_o, exp);
      chk("isk", link_isk_o, (k == 0) ? 8'h55 : 8'h00);
      chk("frame", frame_o, 64'(k));
      chk("bc0", bc0_o, (k == 0) && bc0);
      chk("marker", marker_o, (k == 0) && mk);
      chk("drop", ovf_dropped_o, (k == 0) && drop);
      obs_l0[k] = link_data_o[15:0];
      obs_l2[k] = link_data_o[47:32];
      if (k == 0) begin
        obs_bc0  = bc0_o;
        obs_mk   = marker_o;
        obs_drop = ovf_dropped_o;
        resync_i   = 1'b0;
        clusters_i = rnd_cl();
        overflow_i = 1'($urandom);
        mode_i     = 2'($urandom);
      end
      if (k == 1 && rs_mid) begin
        resync_i    = 1'b1;
        m_force_bc0 = 1'b1;
      end
      if (k == 2) resync_i = 1'b0;
    end
  endtask

  initial begin
    bit [111:0] cl2;
    int         pn;
    reset_n    = 1'b0;
    clusters_i = '0;
    overflow_i = 1'b0;
    resync_i   = 1'b0;
    mode_i     = 2'd0;
    repeat (10) begin
      tick();
      clusters_i = rnd_cl();
      overflow_i = 1'($urandom);
      mode_i     = 2'($urandom);
    end
    check_reset("reset_hold");

    reset_n = 1'b1;
    model_reset();
    cl2 = '0;
    cl2[13:0]  = 14'h1234;
    cl2[27:14] = 14'h0567;
    run_bx(cl2, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("first_bc0", obs_bc0, 1);
    chk("first_w0", obs_l0[0], 16'h341C);
    run_bx(cl2, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t2_l0w0", obs_l0[0], 16'h34BC);
    chk("t2_l0w1", obs_l0[1], 16'h59D2);
    chk("t2_l0w2", obs_l0[2], 16'h0001);
    chk("t2_l0w3", obs_l0[3], 16'h0000);
    chk("t2_l2w0", obs_l2[0], 16'h00BC);
    chk("t2_l2w1", obs_l2[1], 16'h0000);

    for (int i = 0; i < 3564 + 130; i++) begin
      pn = (m_bx + 1) % 3564;
      run_bx(rnd_cl(),
             (pn == 0 || pn == 128 || pn == 5) ? 1'b1
               : ($urandom_range(3) == 0),
             2'd0, 1'b0, 1'b0);
      if (m_bx == 5) chk("ovf_ctrl", obs_l0[0][7:0], 8'hDC);
      if (m_bx == 128 || m_bx == 256) chk("mk_bx", obs_mk, 1);
      if (m_bx == 128) chk("mk_drop", obs_drop, 1);
      if (m_bx == 0) begin
        chk("wrap_bc0", obs_bc0, 1);
        chk("wrap_ctrl", obs_l0[0][7:0], 8'h1C);
        chk("wrap_drop", obs_drop, 1);
      end
    end

    while (m_bx != 499)
      run_bx(rnd_cl(), 1'($urandom), 2'd0, 1'b0, 1'b0);
    run_bx(rnd_cl(), 1'b0, 2'd0, 1'b0, 1'b1);
    run_bx(rnd_cl(), 1'b0, 2'd0, 1'b0, 1'b0);
    chk("rs_bc0", obs_bc0, 1);
    chk("rs_ctrl", obs_l0[0][7:0], 8'h1C);
    repeat (127) run_bx(rnd_cl(), 1'($urandom), 2'd0, 1'b0, 1'b0);
    run_bx(rnd_cl(), 1'b0, 2'd0, 1'b0, 1'b0);
    chk("rs_marker", obs_mk, 1);
    run_bx(rnd_cl(), 1'b0, 2'd0, 1'b1, 1'b0);
    chk("edge_rs_bc0", obs_bc0, 1);

    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check_reset("mid_reset");
    tick();
    tick();
    reset_n = 1'b1;
    model_reset();

    run_bx(rnd_cl(), 1'b1, 2'd3, 1'b0, 1'b0);
    chk("prbs_w0", obs_l0[0], 16'hFF1C);
    chk("prbs_w1", obs_l0[1], 16'hFFFF);
    repeat (10) run_bx(rnd_cl(), 1'($urandom), 2'd3, 1'b0, 1'b0);
    repeat (10) run_bx(rnd_cl(), 1'($urandom), 2'd2, 1'b0, 1'b0);
    repeat (10) run_bx(rnd_cl(), 1'($urandom), 2'd1, 1'b0, 1'b0);
    repeat (60)
      run_bx(rnd_cl(), 1'($urandom), 2'($urandom),
             $urandom_range(15) == 0, $urandom_range(15) == 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
